// File: rtl/fp_unit_arb_pkg.sv
// Shared constants, helper function and default-configuration types for the FP unit arbiter.
// The modules size their own storage from their parameters; these types describe the default build.
package fp_arb_wire;

  localparam int FP_ARB_RMW    = 3;
  localparam int FP_ARB_FFW    = 5;
  localparam int FP_ARB_NCH    = 2;
  localparam int FP_ARB_FLEN   = 32;
  localparam int FP_ARB_OPW    = 5;
  localparam int FP_ARB_RDEPTH = 4;

  function automatic int fp_arb_chw(input int nch);
    if (nch > 1) begin
      return $clog2(nch);
    end else begin
      return 1;
    end
  endfunction

  localparam int FP_ARB_CHW = fp_arb_chw(FP_ARB_NCH);
  localparam int FP_ARB_SLW = $clog2(FP_ARB_RDEPTH);

  typedef struct packed {
    logic [FP_ARB_OPW-1:0]  op;
    logic [FP_ARB_RMW-1:0]  rm;
    logic [FP_ARB_FLEN-1:0] a;
    logic [FP_ARB_FLEN-1:0] b;
    logic [FP_ARB_FLEN-1:0] c;
  } fp_arb_req_type;

  typedef struct packed {
    logic                   alloc;
    logic                   done;
    logic [FP_ARB_FLEN-1:0] res;
    logic [FP_ARB_FFW-1:0]  flags;
  } fp_arb_rob_entry_type;

  typedef struct packed {
    logic [FP_ARB_CHW-1:0] ch;
    logic [FP_ARB_SLW-1:0] slot;
  } fp_arb_tag_type;

endpackage

// File: rtl/fp_unit_arb_rob.sv
// One channel's reorder buffer: allocates at issue, fills on completion, pops results in issue order.
module fp_arb_rob
  import fp_arb_wire::*;
#(
  parameter int FLEN   = 32,
  parameter int RDEPTH = 4,
  parameter int SLW    = $clog2(RDEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue,
  output logic [SLW-1:0]        tail,
  output logic                  full,
  input  logic                  cpl,
  input  logic [SLW-1:0]        cpl_slot,
  input  logic [FLEN-1:0]       cpl_res,
  input  logic [FP_ARB_FFW-1:0] cpl_flags,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [FLEN-1:0]       rsp_res,
  output logic [FP_ARB_FFW-1:0] rsp_flags
);

  typedef struct packed {
    logic                  alloc;
    logic                  done;
    logic [FLEN-1:0]       res;
    logic [FP_ARB_FFW-1:0] flags;
  } rob_entry_type;

  localparam logic [SLW:0] FULL_CNT = (SLW+1)'(RDEPTH);

  rob_entry_type  entry_r [RDEPTH];
  logic [SLW-1:0] head_r;
  logic [SLW-1:0] tail_r;
  logic [SLW:0]   count_r;
  logic           pop_s;

  assign rsp_valid = entry_r[head_r].done && !reset;
  assign rsp_res   = entry_r[head_r].res;
  assign rsp_flags = entry_r[head_r].flags;
  assign pop_s     = rsp_valid && rsp_ready;
  assign tail      = tail_r;
  assign full      = (count_r == FULL_CNT);

  // head/tail pointers wrap naturally because RDEPTH is a power of two
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (issue) tail_r <= tail_r + 1'b1;
      else       tail_r <= tail_r;
      if (pop_s) head_r <= head_r + 1'b1;
      else       head_r <= head_r;
      case ({issue, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // entry state; a completion for an unallocated slot (stale after reset) is dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < RDEPTH; k++) entry_r[k] <= '0;
    end else begin
      if (pop_s) entry_r[head_r] <= '0;
      if (cpl && entry_r[cpl_slot].alloc) begin
        entry_r[cpl_slot].done  <= 1'b1;
        entry_r[cpl_slot].res   <= cpl_res;
        entry_r[cpl_slot].flags <= cpl_flags;
      end
      if (issue) begin
        entry_r[tail_r].alloc <= 1'b1;
        entry_r[tail_r].done  <= 1'b0;
        entry_r[tail_r].res   <= '0;
        entry_r[tail_r].flags <= '0;
      end
    end
  end

endmodule

// File: rtl/fp_unit_arb.sv
// Round-robin front end for the shared FP core with per-channel in-order result return.
// Optional FP_UNIT_ARB_FFLAGS_EN adds sticky per-channel accrued fflags with a clear input.
module fp_unit_arb
  import fp_arb_wire::*;
#(
  parameter int NCH    = 2,
  parameter int FLEN   = 32,
  parameter int OPW    = 5,
  parameter int RDEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NCH-1:0]                req_valid,
  output logic [NCH-1:0]                req_ready,
  input  logic [NCH*OPW-1:0]            req_op,
  input  logic [NCH*FP_ARB_RMW-1:0]     req_rm,
  input  logic [NCH*FLEN-1:0]           req_a,
  input  logic [NCH*FLEN-1:0]           req_b,
  input  logic [NCH*FLEN-1:0]           req_c,
  output logic                          core_valid,
  input  logic                          core_ready,
  output logic [OPW-1:0]                core_op,
  output logic [FP_ARB_RMW-1:0]         core_rm,
  output logic [FLEN-1:0]               core_a,
  output logic [FLEN-1:0]               core_b,
  output logic [FLEN-1:0]               core_c,
  output logic [fp_arb_chw(NCH)+$clog2(RDEPTH)-1:0] core_tag,
  input  logic                          core_done,
  input  logic [fp_arb_chw(NCH)+$clog2(RDEPTH)-1:0] core_rtag,
  input  logic [FLEN-1:0]               core_res,
  input  logic [FP_ARB_FFW-1:0]         core_flags,
  output logic [NCH-1:0]                rsp_valid,
  input  logic [NCH-1:0]                rsp_ready,
  output logic [NCH*FLEN-1:0]           rsp_res,
  output logic [NCH*FP_ARB_FFW-1:0]     rsp_flags
`ifdef FP_UNIT_ARB_FFLAGS_EN
  ,
  output logic [NCH*FP_ARB_FFW-1:0]     fflags,
  input  logic [NCH-1:0]                fflags_clr
`endif
);

  localparam int CHW  = fp_arb_chw(NCH);
  localparam int SLW  = $clog2(RDEPTH);
  localparam int TAGW = CHW + SLW;

  logic [OPW-1:0]        op_s   [NCH];
  logic [FP_ARB_RMW-1:0] rm_s   [NCH];
  logic [FLEN-1:0]       a_s    [NCH];
  logic [FLEN-1:0]       b_s    [NCH];
  logic [FLEN-1:0]       c_s    [NCH];
  logic [SLW-1:0]        tail_s [NCH];
  logic [NCH-1:0]        full_s;
  logic [NCH-1:0]        eligible_s;
  logic [CHW-1:0]        gidx_s;
  logic                  found_s;
  logic                  issue_s;
  logic [CHW-1:0]        rr_ptr_r;
  logic [CHW-1:0]        cpl_ch_s;
  logic [SLW-1:0]        cpl_slot_s;
  int                    idx_s;

  assign cpl_ch_s   = core_rtag[TAGW-1:SLW];
  assign cpl_slot_s = core_rtag[SLW-1:0];

  // first eligible channel at or after rr_ptr, wrapping
  always_comb begin
    gidx_s  = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx_s = int'(rr_ptr_r) + k;
      if (idx_s >= NCH) idx_s = idx_s - NCH;
      else              idx_s = idx_s;
      if (!found_s && eligible_s[idx_s]) begin
        found_s = 1'b1;
        gidx_s  = CHW'(idx_s);
      end else begin
        found_s = found_s;
        gidx_s  = gidx_s;
      end
    end
  end

  assign core_valid = found_s && !reset;
  assign issue_s    = core_valid && core_ready;
  assign core_op    = op_s[gidx_s];
  assign core_rm    = rm_s[gidx_s];
  assign core_a     = a_s[gidx_s];
  assign core_b     = b_s[gidx_s];
  assign core_c     = c_s[gidx_s];
  assign core_tag   = {gidx_s, tail_s[gidx_s]};

  // round-robin pointer moves past the granted channel only on an actual issue
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if (issue_s) begin
      if (int'(gidx_s) == NCH - 1) rr_ptr_r <= '0;
      else                         rr_ptr_r <= gidx_s + 1'b1;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign op_s[i]       = req_op[i*OPW +: OPW];
    assign rm_s[i]       = req_rm[i*FP_ARB_RMW +: FP_ARB_RMW];
    assign a_s[i]        = req_a[i*FLEN +: FLEN];
    assign b_s[i]        = req_b[i*FLEN +: FLEN];
    assign c_s[i]        = req_c[i*FLEN +: FLEN];
    assign eligible_s[i] = req_valid[i] && !full_s[i];
    assign req_ready[i]  = issue_s && (gidx_s == CHW'(i));

    fp_arb_rob #(
      .FLEN   (FLEN),
      .RDEPTH (RDEPTH),
      .SLW    (SLW)
    ) u_rob (
      .clock     (clock),
      .reset     (reset),
      .issue     (issue_s && (gidx_s == CHW'(i))),
      .tail      (tail_s[i]),
      .full      (full_s[i]),
      .cpl       (core_done && (cpl_ch_s == CHW'(i))),
      .cpl_slot  (cpl_slot_s),
      .cpl_res   (core_res),
      .cpl_flags (core_flags),
      .rsp_valid (rsp_valid[i]),
      .rsp_ready (rsp_ready[i]),
      .rsp_res   (rsp_res[i*FLEN +: FLEN]),
      .rsp_flags (rsp_flags[i*FP_ARB_FFW +: FP_ARB_FFW])
    );
  end

`ifdef FP_UNIT_ARB_FFLAGS_EN
  logic [NCH-1:0] pop_s;
  assign pop_s = rsp_valid & rsp_ready;

  // sticky flags; a clear coinciding with a pop keeps only the popped flags
  always_ff @(posedge clock) begin
    if (reset) begin
      fflags <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (pop_s[i] && fflags_clr[i])
          fflags[i*FP_ARB_FFW +: FP_ARB_FFW] <= rsp_flags[i*FP_ARB_FFW +: FP_ARB_FFW];
        else if (fflags_clr[i])
          fflags[i*FP_ARB_FFW +: FP_ARB_FFW] <= '0;
        else if (pop_s[i])
          fflags[i*FP_ARB_FFW +: FP_ARB_FFW] <= fflags[i*FP_ARB_FFW +: FP_ARB_FFW]
                                              | rsp_flags[i*FP_ARB_FFW +: FP_ARB_FFW];
        else
          fflags[i*FP_ARB_FFW +: FP_ARB_FFW] <= fflags[i*FP_ARB_FFW +: FP_ARB_FFW];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_unit_arb.sv
// Directed bench for fp_unit_arb (NCH=2, RDEPTH=4) with a per-channel response scoreboard.
module tb_fp_unit_arb;

  localparam int NCH  = 2;
  localparam int FLEN = 32;
  localparam int OPW  = 5;
  localparam int TAGW = 3;

  logic                clock = 1'b0;
  logic                reset;
  logic [NCH-1:0]      req_valid;
  logic [NCH-1:0]      req_ready;
  logic [NCH*OPW-1:0]  req_op;
  logic [NCH*3-1:0]    req_rm;
  logic [NCH*FLEN-1:0] req_a, req_b, req_c;
  logic                core_valid, core_ready;
  logic [OPW-1:0]      core_op;
  logic [2:0]          core_rm;
  logic [FLEN-1:0]     core_a, core_b, core_c;
  logic [TAGW-1:0]     core_tag;
  logic                core_done;
  logic [TAGW-1:0]     core_rtag;
  logic [FLEN-1:0]     core_res;
  logic [4:0]          core_flags;
  logic [NCH-1:0]      rsp_valid, rsp_ready;
  logic [NCH*FLEN-1:0] rsp_res;
  logic [NCH*5-1:0]    rsp_flags;
`ifdef FP_UNIT_ARB_FFLAGS_EN
  logic [NCH*5-1:0]    fflags;
  logic [NCH-1:0]      fflags_clr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q [NCH][$];

  fp_unit_arb #(.NCH(NCH), .FLEN(FLEN), .OPW(OPW), .RDEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .core_valid(core_valid), .core_ready(core_ready), .core_op(core_op), .core_rm(core_rm),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_tag(core_tag),
    .core_done(core_done), .core_rtag(core_rtag), .core_res(core_res), .core_flags(core_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_flags(rsp_flags)
`ifdef FP_UNIT_ARB_FFLAGS_EN
    , .fflags(fflags), .fflags_clr(fflags_clr)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: every accepted response must match the oldest expectation of its channel
  always @(negedge clock) begin
    logic [36:0] e;
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected_ch%0d: actual res=%0h required no response", i, rsp_res[i*FLEN +: FLEN]);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("rsp_ch%0d", i), {27'd0, rsp_flags[i*5 +: 5], rsp_res[i*FLEN +: FLEN]}, {27'd0, e});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input int ch, input logic [31:0] a, input logic [2:0] tag,
                       input logic [31:0] res, input logic [4:0] flg);
    int waited;
    waited = 0;
    req_valid[ch] = 1'b1;
    req_op[ch*OPW +: OPW] = 5'd3;
    req_a[ch*FLEN +: FLEN] = a;
    @(negedge clock);
    while (!req_ready[ch] && waited < 20) begin
      @(posedge clock);
      #1;
      @(negedge clock);
      waited++;
    end
    check($sformatf("issue_ready_ch%0d", ch), 64'(req_ready[ch]), 64'd1);
    check("issue_tag", 64'(core_tag), 64'(tag));
    check("issue_core_a", 64'(core_a), 64'(a));
    if (req_ready[ch]) exp_q[ch].push_back({flg, res});
    @(posedge clock);
    #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic complete(input logic [2:0] tag, input logic [31:0] res, input logic [4:0] flg);
    core_done  = 1'b1;
    core_rtag  = tag;
    core_res   = res;
    core_flags = flg;
    step();
    core_done  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] t3_tag [4];
    logic [1:0] t3_gnt [4];
    logic [2:0] t4_tag [4];
    t3_tag = '{3'b100, 3'b011, 3'b101, 3'b000};
    t3_gnt = '{2'b10, 2'b01, 2'b10, 2'b01};
    t4_tag = '{3'b001, 3'b010, 3'b011, 3'b000};

    reset = 1'b1; req_valid = 2'b11; core_ready = 1'b1; core_done = 1'b0;
    core_rtag = '0; core_res = '0; core_flags = '0; rsp_ready = 2'b11;
    req_op = '0; req_rm = '0; req_a = {32'h0000_1111, 32'h0000_0000};
    req_b = {32'h0000_2222, 32'h0000_2222}; req_c = '0;
`ifdef FP_UNIT_ARB_FFLAGS_EN
    fflags_clr = '0;
`endif
    // reset state
    @(negedge clock);
    check("reset_core_valid", 64'(core_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    step(); step();
    reset = 1'b0; req_valid = 2'b00;

    // 1: single op, result one cycle after done
    issue(0, 32'h3F80_0000, 3'b000, 32'h4000_0000, 5'b00000);
    step(); step();
    core_done = 1'b1; core_rtag = 3'b000; core_res = 32'h4000_0000; core_flags = 5'b00000;
    @(negedge clock);
    check("t1_rsp_before", 64'(rsp_valid[0]), 64'd0);
    @(posedge clock); #1; core_done = 1'b0;
    @(negedge clock);
    check("t1_rsp_after", 64'(rsp_valid[0]), 64'd1);
    step();

    // 2: out-of-order completion returned in order
    issue(0, 32'h3F80_0001, 3'b001, 32'h1111_1111, 5'b00001);
    issue(0, 32'h3F80_0002, 3'b010, 32'h2222_2222, 5'b00010);
    complete(3'b010, 32'h2222_2222, 5'b00010);
    @(negedge clock);
    check("t2_hold", 64'(rsp_valid[0]), 64'd0);
    @(posedge clock); #1;
    complete(3'b001, 32'h1111_1111, 5'b00001);
    @(negedge clock);
    check("t2_popA", 64'(rsp_valid[0]), 64'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("t2_popB", 64'(rsp_valid[0]), 64'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("t2_empty", 64'(rsp_valid[0]), 64'd0);
    @(posedge clock); #1;

    // 3: both channels requesting, grants alternate starting at rr_ptr=1
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("t3_grant%0d", k), 64'(req_ready), 64'(t3_gnt[k]));
      check($sformatf("t3_tag%0d", k), 64'(core_tag), 64'(t3_tag[k]));
      exp_q[t3_tag[k][2]].push_back({5'(k + 1), 32'h5000_0000 + 32'(k)});
      @(posedge clock); #1;
    end
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) complete(t3_tag[k], 32'h5000_0000 + 32'(k), 5'(k + 1));
    step(); step();

    // 4: full channel skipped, one pop re-enables it
    rsp_ready = 2'b10; req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("t4_grant%0d", k), 64'(req_ready), 64'd1);
      check($sformatf("t4_tag%0d", k), 64'(core_tag), 64'(t4_tag[k]));
      exp_q[0].push_back({5'(k), 32'h4400_0000 + 32'(k)});
      @(posedge clock); #1;
    end
    req_valid = 2'b11;
    @(negedge clock);
    check("t4_full_grant", 64'(req_ready), 64'd2);
    check("t4_ch1_tag", 64'(core_tag), 64'(3'b110));
    exp_q[1].push_back({5'd7, 32'h4411_0000});
    @(posedge clock); #1;
    req_valid = 2'b01;
    core_done = 1'b1; core_rtag = 3'b001; core_res = 32'h4400_0000; core_flags = 5'd0;
    @(negedge clock);
    check("t4_full_valid", 64'(core_valid), 64'd0);
    @(posedge clock); #1;
    core_done = 1'b0; rsp_ready = 2'b11;
    @(negedge clock);
    check("t4_pop_cycle", 64'(req_ready), 64'd0);
    @(posedge clock); #1;
    rsp_ready = 2'b10;
    @(negedge clock);
    check("t4_reissue", 64'(req_ready), 64'd1);
    check("t4_reissue_tag", 64'(core_tag), 64'(3'b001));
    exp_q[0].push_back({5'd4, 32'h4400_0004});
    @(posedge clock); #1;
    req_valid = 2'b00; rsp_ready = 2'b11;
    for (int k = 1; k < 5; k++) complete(t4_tag[k % 4], 32'h4400_0000 + 32'(k), 5'(k));
    complete(3'b110, 32'h4411_0000, 5'd7);
    step(); step(); step();

    // 5: core stall freezes grant, then reset mid-flight
    req_valid = 2'b11; core_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check($sformatf("t5_stall%0d", k), {58'd0, core_valid, req_ready, core_tag}, {58'd0, 1'b1, 2'b00, 3'b111});
      @(posedge clock); #1;
    end
    core_ready = 1'b1;
    @(negedge clock);
    check("t5_release", 64'(req_ready), 64'd2);
    @(posedge clock); #1;
    @(negedge clock);
    check("t5_next", {61'd0, core_tag}, {61'd0, 3'b010});
    @(posedge clock); #1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    complete(3'b111, 32'hDEAD_0001, 5'd1);
    @(negedge clock);
    check("t5_pre_reset", 64'(rsp_valid), 64'd2);
    @(posedge clock); #1;
    reset = 1'b1; req_valid = 2'b11;
    @(negedge clock);
    check("t5_reset_rsp", 64'(rsp_valid), 64'd0);
    check("t5_reset_core", {62'd0, core_valid, |req_ready}, 64'd0);
    step();
    reset = 1'b0; req_valid = 2'b00;
    complete(3'b010, 32'hDEAD_0002, 5'd2);
    complete(3'b111, 32'hDEAD_0003, 5'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("t5_dropped%0d", k), 64'(rsp_valid), 64'd0);
      @(posedge clock); #1;
    end
    rsp_ready = 2'b11;
    issue(0, 32'h3F80_0000, 3'b000, 32'h4040_0000, 5'b00000);
    complete(3'b000, 32'h4040_0000, 5'b00000);
    step(); step();

`ifdef FP_UNIT_ARB_FFLAGS_EN
    // 6: accrued flags and clear-with-pop
    @(negedge clock);
    check("t6_init", 64'(fflags), 64'd0);
    @(posedge clock); #1;
    issue(0, 32'h1, 3'b001, 32'h6000_0001, 5'b00001);
    complete(3'b001, 32'h6000_0001, 5'b00001);
    step();
    issue(0, 32'h2, 3'b010, 32'h6000_0002, 5'b10000);
    complete(3'b010, 32'h6000_0002, 5'b10000);
    step();
    @(negedge clock);
    check("t6_accrue", 64'(fflags), 64'(10'b00000_10001));
    @(posedge clock); #1;
    issue(0, 32'h3, 3'b011, 32'h6000_0003, 5'b00100);
    complete(3'b011, 32'h6000_0003, 5'b00100);
    fflags_clr = 2'b01;
    step();
    fflags_clr = 2'b00;
    @(negedge clock);
    check("t6_clr_pop", 64'(fflags), 64'(10'b00000_00100));
    @(posedge clock); #1;
`endif

    step(); step();
    check("q0_drained", 64'(exp_q[0].size()), 64'd0);
    check("q1_drained", 64'(exp_q[1].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
